dc_fu_line_scheduler: RTL and testbench
=======================================

DC_FU_LINE_SCHEDULER -- requirements
Module: dc_fu_line_scheduler

Interface
REQ-001 SHALL have parameter AXI_ARADDR_WIDTH, 32, frame base address width.
REQ-002 SHALL have parameter PIXELS_PER_LINE_WIDTH, 8, pixels-per-line field width.
REQ-003 SHALL have parameter LINE_NUMBER_WIDTH, 8, line index and line count width.
REQ-004 SHALL have parameter FIFO_LEVEL_WIDTH, 10, pixel FIFO occupancy width.
REQ-005 SHALL have parameter FIFO_DEPTH, 512, pixel FIFO capacity in pixels.
REQ-006 SHALL have one clock and a synchronous active-low reset: clk  in  1  clock; nrst  in  1  synchronous active-low reset, sampled on rising clk.
REQ-007 SHALL have ports: en  in  1  clock enable; frame_start  in  1  one-cycle frame request; cfg_frame_addr  in  AXI_ARADDR_WIDTH  frame base; cfg_pixels_per_line  in  PIXELS_PER_LINE_WIDTH  line length; cfg_lines_per_frame  in  LINE_NUMBER_WIDTH  frame height.
REQ-008 SHALL have ports: fifo_level  in  FIFO_LEVEL_WIDTH  pixel FIFO occupancy; pixel_fifo_en  in  1  one pixel written to FIFO.
REQ-009 SHALL have ports to the fetching unit: frame_addr  out  AXI_ARADDR_WIDTH; pixels_per_line  out  PIXELS_PER_LINE_WIDTH; line_number  out  LINE_NUMBER_WIDTH; line_data_valid  out  1; line_data_ready  in  1.
REQ-010 SHALL have status ports: busy  out  1; frame_done  out  1  one-cycle pulse; cfg_error  out  1  one-cycle pulse; frame_overrun  out  1  sticky.

Function
REQ-011 SHALL implement states IDLE, WAIT_SPACE, REQ, FETCH, DONE.
REQ-012 SHALL, in IDLE on frame_start with nonzero cfg_pixels_per_line and cfg_lines_per_frame, latch all cfg_* into shadow registers, clear line counter, enter WAIT_SPACE next cycle.
REQ-013 SHALL, in IDLE on frame_start with zero cfg_pixels_per_line or zero cfg_lines_per_frame, stay IDLE and pulse cfg_error one cycle.
REQ-014 SHALL drive frame_addr and pixels_per_line from shadow registers and line_number from the line counter, all stable outside IDLE.
REQ-015 SHALL, in WAIT_SPACE, move to REQ when FIFO_DEPTH - fifo_level >= pixels_per_line, compared at FIFO_LEVEL_WIDTH+1 bits unsigned; otherwise remain.
REQ-016 SHALL assert line_data_valid exactly while in REQ; line_number SHALL not change while valid is high.
REQ-017 SHALL leave REQ for FETCH on the cycle after line_data_valid && line_data_ready; valid SHALL not drop without ready.
REQ-018 SHALL, in FETCH, count pixel_fifo_en pulses from zero; pulses in any other state SHALL be ignored.
REQ-019 SHALL, when the count reaches pixels_per_line, go to DONE if line_number == lines_per_frame-1, else increment line_number and go to WAIT_SPACE.
REQ-020 SHALL, in DONE, pulse frame_done for one cycle and return to IDLE next cycle.
REQ-021 SHALL drive busy high in every state except IDLE.
REQ-022 SHALL ignore frame_start outside IDLE and set frame_overrun, which stays high until reset.
REQ-023 SHALL, when en is low, hold all state, counters and outputs; frame_done and cfg_error SHALL not pulse.
REQ-024 SHALL wrap no counter; line_number maximum is 2^LINE_NUMBER_WIDTH-1.

Reset
REQ-025 SHALL, on nrst low at a clock edge, regardless of en or state, enter IDLE and clear frame_addr, pixels_per_line, line_number, pixel count, line_data_valid, busy, frame_done, cfg_error and frame_overrun to 0.
REQ-026 SHALL, on reset during FETCH or REQ, drop line_data_valid the following cycle and discard in-flight progress.

Verification
REQ-027 SHALL cover normal frame: addr 0x1000, 4 px/line, 3 lines, fifo_level 0, ready always high -> line_number 0,1,2 each requested once, frame_done pulses once after the 12th pixel_fifo_en, then busy low.
REQ-028 SHALL cover backpressure: FIFO_DEPTH 512, fifo_level 510, 4 px/line -> stays WAIT_SPACE, no valid; fifo_level 508 -> valid next cycle.
REQ-029 SHALL cover handshake hold: ready low 5 cycles in REQ -> valid high and line_number constant for all 5, FETCH one cycle after ready.
REQ-030 SHALL cover config errors: frame_start with lines_per_frame 0 -> cfg_error one cycle, busy stays 0.
REQ-031 SHALL cover overrun and en: frame_start during FETCH -> frame_overrun 1, frame unaffected; en low 3 cycles mid-line -> pixel count frozen, pixel_fifo_en ignored.
REQ-032 SHALL cover reset mid-line: nrst low in FETCH after 2 of 4 pixels -> all outputs 0 next cycle; new frame restarts at line 0.

Source files
------------

// File: rtl/dc_fu_line_scheduler.sv
// ============================================================================
// Module      : dc_fu_line_scheduler
// Description : Per-line fetch scheduler for the display controller fetch unit.
//               Requests one line at a time once the pixel FIFO has room for it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_fu_line_scheduler #(
    parameter int AXI_ARADDR_WIDTH      = 32,
    parameter int PIXELS_PER_LINE_WIDTH = 8,
    parameter int LINE_NUMBER_WIDTH     = 8,
    parameter int FIFO_LEVEL_WIDTH      = 10,
    parameter int FIFO_DEPTH            = 512
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             en,
    input  logic                             frame_start,
    input  logic [AXI_ARADDR_WIDTH-1:0]      cfg_frame_addr,
    input  logic [PIXELS_PER_LINE_WIDTH-1:0] cfg_pixels_per_line,
    input  logic [LINE_NUMBER_WIDTH-1:0]     cfg_lines_per_frame,
    input  logic [FIFO_LEVEL_WIDTH-1:0]      fifo_level,
    input  logic                             pixel_fifo_en,
    output logic [AXI_ARADDR_WIDTH-1:0]      frame_addr,
    output logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    output logic [LINE_NUMBER_WIDTH-1:0]     line_number,
    output logic                             line_data_valid,
    input  logic                             line_data_ready,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             cfg_error,
    output logic                             frame_overrun
);

    localparam int c_lvl_w = FIFO_LEVEL_WIDTH + 1;
    localparam int c_cnt_w = PIXELS_PER_LINE_WIDTH + 1;
    localparam logic [c_lvl_w-1:0] c_fifo_depth = c_lvl_w'(FIFO_DEPTH);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_wait_space = 3'd1;
    localparam logic [2:0] c_st_req        = 3'd2;
    localparam logic [2:0] c_st_fetch      = 3'd3;
    localparam logic [2:0] c_st_done       = 3'd4;

    logic [2:0]                       r_state;
    logic [AXI_ARADDR_WIDTH-1:0]      r_frame_addr;
    logic [PIXELS_PER_LINE_WIDTH-1:0] r_ppl;
    logic [LINE_NUMBER_WIDTH-1:0]     r_lpf;
    logic [LINE_NUMBER_WIDTH-1:0]     r_line;
    logic [PIXELS_PER_LINE_WIDTH-1:0] r_pix_cnt;
    logic                             r_valid;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_err;
    logic                             r_ovr;

    logic [c_lvl_w-1:0] w_level_ext;
    logic [c_lvl_w-1:0] w_space;
    logic [c_lvl_w-1:0] w_ppl_ext;
    logic               w_space_ok;
    logic [c_cnt_w-1:0] w_pix_next;
    logic               w_line_end;
    logic               w_last_line;
    logic               w_cfg_ok;

    // A level above the depth would wrap the subtraction, so it never counts as room.
    assign w_level_ext = {1'b0, fifo_level};
    assign w_space     = c_fifo_depth - w_level_ext;
    assign w_ppl_ext   = c_lvl_w'(r_ppl);
    assign w_space_ok  = (w_level_ext <= c_fifo_depth) && (w_space >= w_ppl_ext);

    assign w_pix_next  = {1'b0, r_pix_cnt} + c_cnt_w'(1);
    assign w_line_end  = (w_pix_next == {1'b0, r_ppl});
    assign w_last_line = (r_line == (r_lpf - LINE_NUMBER_WIDTH'(1)));
    assign w_cfg_ok    = (cfg_pixels_per_line != '0) && (cfg_lines_per_frame != '0);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= c_st_idle;
            r_frame_addr <= '0;
            r_ppl        <= '0;
            r_lpf        <= '0;
            r_line       <= '0;
            r_pix_cnt    <= '0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_ovr        <= 1'b0;
        end else if (!en) begin
            // Everything freezes; only the single-cycle pulses are withdrawn.
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (frame_start && (r_state != c_st_idle)) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (frame_start) begin
                        if (w_cfg_ok) begin
                            r_frame_addr <= cfg_frame_addr;
                            r_ppl        <= cfg_pixels_per_line;
                            r_lpf        <= cfg_lines_per_frame;
                            r_line       <= '0;
                            r_pix_cnt    <= '0;
                            r_busy       <= 1'b1;
                            r_state      <= c_st_wait_space;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end

                c_st_wait_space: begin
                    if (w_space_ok) begin
                        r_valid <= 1'b1;
                        r_state <= c_st_req;
                    end
                end

                c_st_req: begin
                    if (line_data_ready) begin
                        r_valid   <= 1'b0;
                        r_pix_cnt <= '0;
                        r_state   <= c_st_fetch;
                    end
                end

                c_st_fetch: begin
                    if (pixel_fifo_en) begin
                        if (w_line_end) begin
                            r_pix_cnt <= '0;
                            if (w_last_line) begin
                                r_done  <= 1'b1;
                                r_state <= c_st_done;
                            end else begin
                                r_line  <= r_line + LINE_NUMBER_WIDTH'(1);
                                r_state <= c_st_wait_space;
                            end
                        end else begin
                            r_pix_cnt <= w_pix_next[PIXELS_PER_LINE_WIDTH-1:0];
                        end
                    end
                end

                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign frame_addr      = r_frame_addr;
    assign pixels_per_line = r_ppl;
    assign line_number     = r_line;
    assign line_data_valid = r_valid;
    assign busy            = r_busy;
    assign frame_done      = r_done;
    assign cfg_error       = r_err;
    assign frame_overrun   = r_ovr;

endmodule

`default_nettype wire

// File: tb/tb_dc_fu_line_scheduler.sv
// ============================================================================
// Module      : tb_dc_fu_line_scheduler
// Description : Directed vector table plus multi-cycle sequences for the line scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dc_fu_line_scheduler;

    logic        clk;
    logic        nrst;
    logic        en;
    logic        frame_start;
    logic [31:0] cfg_frame_addr;
    logic [7:0]  cfg_pixels_per_line;
    logic [7:0]  cfg_lines_per_frame;
    logic [9:0]  fifo_level;
    logic        pixel_fifo_en;
    logic [31:0] frame_addr;
    logic [7:0]  pixels_per_line;
    logic [7:0]  line_number;
    logic        line_data_valid;
    logic        line_data_ready;
    logic        busy;
    logic        frame_done;
    logic        cfg_error;
    logic        frame_overrun;

    int n_checks = 0;
    int n_errors = 0;

    dc_fu_line_scheduler dut (
        .clk                 (clk),
        .nrst                (nrst),
        .en                  (en),
        .frame_start         (frame_start),
        .cfg_frame_addr      (cfg_frame_addr),
        .cfg_pixels_per_line (cfg_pixels_per_line),
        .cfg_lines_per_frame (cfg_lines_per_frame),
        .fifo_level          (fifo_level),
        .pixel_fifo_en       (pixel_fifo_en),
        .frame_addr          (frame_addr),
        .pixels_per_line     (pixels_per_line),
        .line_number         (line_number),
        .line_data_valid     (line_data_valid),
        .line_data_ready     (line_data_ready),
        .busy                (busy),
        .frame_done          (frame_done),
        .cfg_error           (cfg_error),
        .frame_overrun       (frame_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nrst;
        logic       en;
        logic       fs;
        logic [7:0] ppl;
        logic [7:0] lpf;
        logic [9:0] lvl;
        logic       pix;
        logic       rdy;
        logic       e_busy;
        logic       e_valid;
        logic [7:0] e_ln;
        logic       e_done;
        logic       e_err;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int          req_cnt;
    logic [7:0]  req_lines [4];
    int          done_cnt;
    int          done_cyc;

    initial begin
        nrst = 1'b0; en = 1'b1; frame_start = 1'b0;
        cfg_frame_addr = 32'h1000; cfg_pixels_per_line = 8'd0; cfg_lines_per_frame = 8'd0;
        fifo_level = 10'd0; pixel_fifo_en = 1'b0; line_data_ready = 1'b0;

        //            nrst en fs ppl    lpf    lvl      pix rdy  busy vld ln    done err ovr
        vecs[0]  = '{1'b0,1'b1,1'b0,8'd0,8'd0,10'd0,  1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b1,1'b1,8'd4,8'd0,10'd0,  1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b0,8'd4,8'd0,10'd0,  1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b1,8'd0,8'd3,10'd0,  1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b1,8'd4,8'd1,10'd510,1'b0,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd510,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd510,1'b0,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b0,1'b0, 1'b1,1'b1,8'd0,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b0,1'b1, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b0,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b1,1'b0, 1'b1,1'b0,8'd0,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b1,1'b0,8'd4,8'd1,10'd508,1'b0,1'b0, 1'b0,1'b0,8'd0,1'b0,1'b0,1'b0};

        for (int i = 0; i < 14; i++) begin
            nrst = vecs[i].nrst; en = vecs[i].en; frame_start = vecs[i].fs;
            cfg_pixels_per_line = vecs[i].ppl; cfg_lines_per_frame = vecs[i].lpf;
            fifo_level = vecs[i].lvl; pixel_fifo_en = vecs[i].pix; line_data_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d busy", i),  32'(busy),            32'(vecs[i].e_busy));
            chk($sformatf("vec%0d valid", i), 32'(line_data_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d line", i),  32'(line_number),     32'(vecs[i].e_ln));
            chk($sformatf("vec%0d done", i),  32'(frame_done),      32'(vecs[i].e_done));
            chk($sformatf("vec%0d err", i),   32'(cfg_error),       32'(vecs[i].e_err));
            chk($sformatf("vec%0d ovr", i),   32'(frame_overrun),   32'(vecs[i].e_ovr));
            if (i == 0) begin
                chk("reset frame_addr", frame_addr, 32'h0);
                chk("reset ppl", 32'(pixels_per_line), 32'h0);
            end
        end

        // Normal 3-line frame, pixels offered every cycle, ready always high.
        cfg_pixels_per_line = 8'd4; cfg_lines_per_frame = 8'd3; fifo_level = 10'd0;
        line_data_ready = 1'b1; pixel_fifo_en = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req_cnt = 0; done_cnt = 0; done_cyc = -1;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (line_data_valid) begin
                if (req_cnt < 4) req_lines[req_cnt] = line_number;
                req_cnt++;
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c == 5) begin
                chk("normal frame_addr", frame_addr, 32'h1000);
                chk("normal ppl", 32'(pixels_per_line), 32'd4);
            end
        end
        chk("normal req count", req_cnt, 3);
        chk("normal req line0", 32'(req_lines[0]), 32'd0);
        chk("normal req line1", 32'(req_lines[1]), 32'd1);
        chk("normal req line2", 32'(req_lines[2]), 32'd2);
        chk("normal done count", done_cnt, 1);
        chk("normal done cycle", done_cyc, 18);
        chk("normal busy after", 32'(busy), 32'd0);

        // Handshake hold: ready low for five cycles in REQ.
        pixel_fifo_en = 1'b0; line_data_ready = 1'b0;
        cfg_pixels_per_line = 8'd2; cfg_lines_per_frame = 8'd1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("hold busy", 32'(busy), 32'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold valid%0d", k), 32'(line_data_valid), 32'd1);
            chk($sformatf("hold line%0d", k), 32'(line_number), 32'd0);
        end
        line_data_ready = 1'b1;
        step();
        chk("hold valid after ready", 32'(line_data_valid), 32'd0);
        line_data_ready = 1'b0; pixel_fifo_en = 1'b1;
        step();
        chk("hold done early", 32'(frame_done), 32'd0);
        step();
        chk("hold done", 32'(frame_done), 32'd1);
        pixel_fifo_en = 1'b0;
        step();
        chk("hold busy end", 32'(busy), 32'd0);

        // Overrun during FETCH, then enable low mid-line.
        cfg_pixels_per_line = 8'd4; cfg_lines_per_frame = 8'd1;
        line_data_ready = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        pixel_fifo_en = 1'b1;
        step();
        pixel_fifo_en = 1'b0; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("ovr set", 32'(frame_overrun), 32'd1);
        chk("ovr busy", 32'(busy), 32'd1);
        chk("ovr valid", 32'(line_data_valid), 32'd0);
        en = 1'b0; pixel_fifo_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("en_low busy%0d", k), 32'(busy), 32'd1);
            chk($sformatf("en_low done%0d", k), 32'(frame_done), 32'd0);
        end
        en = 1'b1;
        step();
        step();
        chk("en pixel3 no done", 32'(frame_done), 32'd0);
        step();
        chk("en pixel4 done", 32'(frame_done), 32'd1);
        pixel_fifo_en = 1'b0;
        step();
        chk("ovr busy end", 32'(busy), 32'd0);
        chk("ovr sticky", 32'(frame_overrun), 32'd1);

        // Reset in the middle of line 1.
        nrst = 1'b0;
        step();
        chk("rst clears ovr", 32'(frame_overrun), 32'd0);
        nrst = 1'b1;
        cfg_pixels_per_line = 8'd4; cfg_lines_per_frame = 8'd2; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        pixel_fifo_en = 1'b1;
        for (int k = 0; k < 4; k++) step();
        pixel_fifo_en = 1'b0;
        step();
        chk("mid valid line1", 32'(line_data_valid), 32'd1);
        chk("mid line1", 32'(line_number), 32'd1);
        step();
        pixel_fifo_en = 1'b1;
        step();
        step();
        pixel_fifo_en = 1'b0; nrst = 1'b0;
        step();
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst valid", 32'(line_data_valid), 32'd0);
        chk("mid rst line", 32'(line_number), 32'd0);
        chk("mid rst addr", frame_addr, 32'd0);
        chk("mid rst ppl", 32'(pixels_per_line), 32'd0);
        chk("mid rst done", 32'(frame_done), 32'd0);
        nrst = 1'b1; frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("restart valid", 32'(line_data_valid), 32'd1);
        chk("restart line", 32'(line_number), 32'd0);
        chk("restart addr", frame_addr, 32'h1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
